// File: rtl/fir_sample_tx_if.sv
// Upstream sample handshake into the serial transmitter.
// The master drives samples; the slave (the transmitter) returns in_ready.
interface fir_sample_tx_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/fir_sample_tx.sv
// Serializes filtered samples MSB-first onto a 3-wire link (sclk, sdata, frame).
// Frames run back to back when the next sample is accepted on the last cycle of a frame.
module fir_sample_tx #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    fir_sample_tx_if.slave   up,
    output logic             sclk,
    output logic             sdata,
    output logic             frame,
    output logic             busy
);

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
        $error("fir_sample_tx: CLK_DIV must be even and >= 2");
    end
    if (DATA_W < 2) begin : g_bad_data_w
        $error("fir_sample_tx: DATA_W must be >= 2");
    end

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              sclk_q, sclk_d;
    logic              sdata_q, sdata_d;
    logic              frame_q, frame_d;
    logic              busy_q, busy_d;

    logic last_cycle;
    logic ready;
    logic xfer;

    // Ready depends on state and counters only, so upstream can never form a loop through it.
    assign last_cycle  = (state_q == StShift) && (bit_cnt_q == BIT_LAST) && (div_q == DIV_LAST);
    assign ready       = (state_q == StIdle) || last_cycle;
    assign xfer        = up.in_valid && ready;
    assign up.in_ready = ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        sclk_d    = sclk_q;
        sdata_d   = sdata_q;
        frame_d   = frame_q;
        busy_d    = busy_q;

        unique case (state_q)
            StIdle: begin
            end
            StShift: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = StIdle;
                        shreg_d   = '0;
                        bit_cnt_d = '0;
                        sdata_d   = 1'b0;
                        frame_d   = 1'b0;
                        busy_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                        sdata_d   = shreg_q[DATA_W-2];
                        frame_d   = 1'b0;
                    end
                end else begin
                    div_d  = div_q + DIV_W'(1);
                    sclk_d = (div_q + DIV_W'(1)) >= DIV_HALF;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A transfer can only happen in idle or on the final cycle, so it overrides the above.
        if (xfer) begin
            state_d   = StShift;
            shreg_d   = up.in_data;
            bit_cnt_d = '0;
            div_d     = '0;
            sclk_d    = 1'b0;
            sdata_d   = up.in_data[DATA_W-1];
            frame_d   = 1'b1;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            frame_q   <= frame_d;
            busy_q    <= busy_d;
        end
    end

    assign sclk  = sclk_q;
    assign sdata = sdata_q;
    assign frame = frame_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_fir_sample_tx.sv
// Directed bench for fir_sample_tx: vector table of single frames plus
// back-to-back, backpressure, mid-frame reset, idle hold and CLK_DIV=2 sequences.
module tb_fir_sample_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fir_sample_tx_if #(.DATA_W(16)) bus ();
    fir_sample_tx_if #(.DATA_W(16)) bus2 ();

    logic sclk, sdata, frame, busy;
    logic sclk2, sdata2, frame2, busy2;

    fir_sample_tx #(.DATA_W(16), .CLK_DIV(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .up    (bus),
        .sclk  (sclk),
        .sdata (sdata),
        .frame (frame),
        .busy  (busy)
    );

    fir_sample_tx #(.DATA_W(16), .CLK_DIV(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .up    (bus2),
        .sclk  (sclk2),
        .sdata (sdata2),
        .frame (frame2),
        .busy  (busy2)
    );

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic sd;
        logic fr;
        logic sc;
        logic bz;
        logic rd;
        logic acc;
    } samp_t;

    localparam int F_SD = 5;
    localparam int F_FR = 4;
    localparam int F_SC = 3;
    localparam int F_BZ = 2;
    localparam int F_RD = 1;
    localparam int F_ACC = 0;

    samp_t smp [0:255];
    logic [15:0] pend [$];

    typedef struct {
        logic [15:0] w;
        logic [15:0] exp_w;
        int          exp_hi;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One record per negedge; acc marks that the following posedge accepts a sample.
    task automatic run(input int n, input int t0, input int t1);
        int   taken = 0;
        logic acc_prev = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (acc_prev) bus.in_valid = 1'b0;
            if (!bus.in_valid && pend.size() > 0 && c >= ((taken == 0) ? t0 : t1)) begin
                bus.in_valid = 1'b1;
                bus.in_data  = pend.pop_front();
            end
            smp[c].sd  = sdata;
            smp[c].fr  = frame;
            smp[c].sc  = sclk;
            smp[c].bz  = busy;
            smp[c].rd  = bus.in_ready;
            smp[c].acc = bus.in_valid && bus.in_ready;
            acc_prev   = smp[c].acc;
            if (acc_prev) taken++;
        end
    endtask

    function automatic int cnt(input int f, input int s, input int e);
        int n = 0;
        for (int k = s; k <= e; k++) n += int'(smp[k][f]);
        return n;
    endfunction

    function automatic int sclk_err(input int s, input int e);
        int n = 0;
        for (int k = s; k <= e; k++)
            if (smp[k][F_SC] != (((k - s) % 4) >= 2)) n++;
        return n;
    endfunction

    function automatic int rises(input int s, input int e);
        int n = 0;
        for (int k = s; k <= e; k++)
            if (smp[k][F_SC] && (k == s || !smp[k-1][F_SC])) n++;
        return n;
    endfunction

    function automatic logic [15:0] decode(input int s, input int e);
        logic [15:0] w = '0;
        for (int k = s; k <= e; k++)
            if (smp[k][F_SC] && (k == s || !smp[k-1][F_SC])) w = {w[14:0], smp[k][F_SD]};
        return w;
    endfunction

    function automatic int pattern_err(input int s, input logic [15:0] w);
        int n = 0;
        for (int j = 0; j < 64; j++)
            if (smp[s+j][F_SD] != w[15 - (j / 4)]) n++;
        return n;
    endfunction

    task automatic check_frame(input string nm, input int s, input logic [15:0] exp_w,
                               input int exp_hi);
        chk({nm, " word"}, int'(decode(s, s + 63)), int'(exp_w));
        chk({nm, " rises"}, rises(s, s + 63), 16);
        chk({nm, " sdata_hi"}, cnt(F_SD, s, s + 63), exp_hi);
        chk({nm, " sdata_pat"}, pattern_err(s, exp_w), 0);
        chk({nm, " frame_first4"}, cnt(F_FR, s, s + 3), 4);
        chk({nm, " frame_total"}, cnt(F_FR, s, s + 63), 4);
        chk({nm, " busy"}, cnt(F_BZ, s, s + 63), 64);
        chk({nm, " sclk_pat"}, sclk_err(s, s + 63), 0);
        chk({nm, " ready_low"}, cnt(F_RD, s, s + 62), 0);
        chk({nm, " ready_last"}, int'(smp[s+63][F_RD]), 1);
    endtask

    initial begin
        int idle_bad;
        int e_sd, e_sc, e_fr, e_bz;

        vecs[0] = '{16'hA5C3, 16'hA5C3, 32};
        vecs[1] = '{16'h0000, 16'h0000, 0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 64};
        vecs[3] = '{16'h0001, 16'h0001, 4};
        vecs[4] = '{16'h1234, 16'h1234, 20};
        vecs[5] = '{16'h8001, 16'h8001, 8};
        vecs[6] = '{16'h7FFE, 16'h7FFE, 56};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset outs", int'({sclk, sdata, frame, busy, bus.in_ready}), 1);
        reset = 1'b0;

        // Idle hold
        run(100, 0, 0);
        idle_bad = 0;
        for (int k = 0; k < 100; k++) if (smp[k][5:1] != 5'b00001) idle_bad++;
        chk("idle hold", idle_bad, 0);

        // Single frames from idle
        for (int i = 0; i < 7; i++) begin
            pend.push_back(vecs[i].w);
            run(70, 0, 0);
            chk($sformatf("vec%0d accept", i), int'(smp[0][F_ACC]), 1);
            check_frame($sformatf("vec%0d", i), 1, vecs[i].exp_w, vecs[i].exp_hi);
            chk($sformatf("vec%0d idle_after", i), int'(smp[65][5:1]), 1);
        end

        // Back-to-back
        pend.push_back(16'h8001);
        pend.push_back(16'h7FFE);
        run(140, 0, 0);
        chk("b2b accepts", cnt(F_ACC, 0, 139), 2);
        chk("b2b accept64", int'(smp[64][F_ACC]), 1);
        check_frame("b2b1", 1, 16'h8001, 8);
        check_frame("b2b2", 65, 16'h7FFE, 56);
        chk("b2b sclk_cont", sclk_err(1, 128), 0);
        chk("b2b frame65", int'({smp[65][F_FR], smp[65][F_SD]}), 2);
        chk("b2b idle_after", int'(smp[129][5:1]), 1);

        // Backpressure: second sample offered at cycle 10 of the first frame
        pend.push_back(16'hA5C3);
        pend.push_back(16'h1234);
        run(140, 0, 10);
        chk("bp no_early_acc", cnt(F_ACC, 1, 63), 0);
        chk("bp accept64", int'(smp[64][F_ACC]), 1);
        check_frame("bp1", 1, 16'hA5C3, 32);
        check_frame("bp2", 65, 16'h1234, 20);

        // Reset during bit 7 of 0xFFFF, with a sample offered while reset is held
        pend.push_back(16'hFFFF);
        run(30, 0, 0);
        chk("rst pre busy", int'({sdata, busy}), 3);
        #2;
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hBEEF;
        #1;
        chk("rst immediate", int'({sclk, sdata, frame, busy, bus.in_ready}), 1);
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        run(10, 0, 0);
        chk("rst no_retx", cnt(F_BZ, 0, 9), 0);
        pend.push_back(16'h0001);
        run(70, 0, 0);
        check_frame("post_rst", 1, 16'h0001, 4);

        // CLK_DIV=2 instance
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.in_data  = 16'hC000;
        chk("d2 ready", int'(bus2.in_ready), 1);
        e_sd = 0; e_sc = 0; e_fr = 0; e_bz = 0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 1) bus2.in_valid = 1'b0;
            if (sdata2 != (c <= 4)) e_sd++;
            if (sclk2 != (c <= 32 && ((c - 1) % 2) == 1)) e_sc++;
            if (frame2 != (c <= 2)) e_fr++;
            if (busy2 != (c <= 32)) e_bz++;
        end
        chk("d2 sdata", e_sd, 0);
        chk("d2 sclk", e_sc, 0);
        chk("d2 frame", e_fr, 0);
        chk("d2 busy", e_bz, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_sample_tx.md
Name: fir_sample_tx

Overview:
- Transmit end of the filter output path: accepts 16-bit filtered samples over a valid/ready handshake.
- Serializes each sample MSB-first onto a 3-wire synchronous link (serial clock, serial data, frame sync) for the external DAC/codec.
- Sits downstream of the tap-sum/output register stage.
- Provides back-to-back framing with zero gap between samples when the upstream stage keeps data valid.

Parameters:
- DATA_W, 16: sample width in bits; also the number of bit periods per frame.
- CLK_DIV, 4: clk cycles per serial bit period. Must be even and >= 2; any other value is an elaboration-time error.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  sample to transmit, two's complement, sent as raw bits.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- sclk  output  1  serial bit clock; receiver samples sdata on the sclk rising edge.
- sdata  output  1  serial data, MSB first.
- frame  output  1  high for the whole bit period of the MSB of each sample.
- busy  output  1  high while a frame is being shifted out.

Behaviour:
- Reset: asynchronous, active-high, takes effect immediately.
  - Forces state IDLE, shift register 0, bit counter 0, divider counter 0.
  - Outputs: sclk=0, sdata=0, frame=0, busy=0, in_ready=1.
  - Reset mid-frame aborts the frame at once; the partial sample is discarded and not retransmitted.
- Registers: sclk, sdata, frame and busy are registered. in_ready is combinational from state and counters only, never from in_valid.
- States: IDLE and SHIFT.
- Handshake:
  - A transfer occurs on a rising edge where in_valid=1 and in_ready=1. in_data is latched into the shift register.
  - in_ready=1 in IDLE.
  - In SHIFT, in_ready=1 only on the final clk cycle of the final bit period (bit counter=DATA_W-1 and divider=CLK_DIV-1). It is 0 on every other SHIFT cycle.
  - in_data/in_valid are ignored while in_ready=0; upstream must hold them.
- IDLE -> SHIFT on a transfer.
  - On the next cycle: sdata=MSB, frame=1, busy=1, sclk=0, divider=0, bit counter=0.
  - Latency from the accepting edge to the first bit on sdata: 1 cycle.
- SHIFT, per bit period of CLK_DIV cycles:
  - sclk=0 for the first CLK_DIV/2 cycles, then 1 for the last CLK_DIV/2 cycles.
  - sdata changes only at the start of a bit period (the cycle after sclk falls, or the cycle after the transfer edge for bit 0).
  - frame=1 only during bit period 0; 0 for bit periods 1..DATA_W-1.
- End of frame, at the last cycle of bit DATA_W-1:
  - If a transfer occurs: stay in SHIFT and start the new frame on the next cycle with no idle gap. frame rises again, sdata=new MSB.
  - Otherwise: go to IDLE. Next cycle sclk=0, sdata=0, frame=0, busy=0.
- Frame length: exactly DATA_W*CLK_DIV clk cycles. There are no extra sclk edges; sclk never glitches outside SHIFT.
- Simultaneous reset and transfer: reset wins and the sample is dropped.

Test Plan:
- Single frame, DATA_W=16, CLK_DIV=4, send 0xA5C3 from IDLE:
  - sdata shows 1010_0101_1100_0011, each bit held 4 cycles.
  - frame=1 for cycles 1-4 after the accepting edge.
  - sclk pattern 0011 repeated 16 times.
  - busy=1 for 64 cycles, then all outputs 0.
- Back-to-back, in_valid held with 0x8001 then 0x7FFE:
  - in_ready pulses only at cycle 64 of the first frame.
  - The second frame starts at cycle 65 with frame=1, sdata=0, and no gap in the sclk pattern.
  - Received words decode as 0x8001, 0x7FFE.
- Backpressure, in_valid asserted at cycle 10 of a frame with 0x1234:
  - in_ready=0 until cycle 64.
  - 0x1234 is accepted at cycle 64 and transmitted next; the first frame is unaltered.
- Reset mid-frame, reset asserted during bit 7 of 0xFFFF:
  - sclk, sdata, frame and busy go to 0 immediately; in_ready=1.
  - After release, sending 0x0001 produces a clean full frame.
- Idle hold: in_valid=0 for 100 cycles after reset -> sclk, sdata, frame stay 0, in_ready stays 1.
- CLK_DIV=2 build, send 0xC000:
  - sclk toggles 0,1 per bit; frame=1 for 2 cycles.
  - sdata=1 for 4 cycles, then 0 for 28 cycles; total 32 cycles.
